ntt_result_collector: RTL and testbench

Receive-side unloader for the NTT1024 core's output stream. After the core asserts `done`, it captures the interleaved `dout0` word stream and maps each word back to its natural coefficient index: even words go to the low half, odd words to the high half. Each coefficient gets one conditional subtraction of q, and the result is written to an internal buffer. The host reads the buffer through a registered port, so the collector replaces the bench-side capture and reduction logic in the top-level integration.

---
 rtl/ntt_result_collector.sv | 133 +++++++++++++
 tb/tb_ntt_result_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_result_collector.sv
// ============================================================================
// Module   : ntt_result_collector
// Brief    : Unloads the NTT1024 interleaved dout0 stream into a naturally
//            ordered, once-reduced coefficient buffer with a registered read.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_result_collector #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [11:0]       ring_size,
    input  logic [DATA_W-1:0] q,
    input  logic              done,
    input  logic              dout_valid,
    input  logic [DATA_W-1:0] dout0,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              ovf,
    output logic              err
);

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_S_CAPTURE   = 2'd2;
    localparam logic [1:0] c_S_READY     = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_m;
    logic [11:0]       r_ring_size;
    logic [DATA_W-1:0] r_q;
    logic              r_ovf;
    logic              r_err;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_half;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic              w_over;
    logic [DATA_W-1:0] w_wdata;

    // A concurrent arm wins over an incoming word, so the word is dropped.
    assign w_accept = (r_state == c_S_CAPTURE) && dout_valid && !arm;
    assign w_last   = (32'(r_m) == (32'(r_ring_size) - 32'd1));
    assign w_half   = ADDR_W'(r_ring_size >> 1);
    assign w_waddr  = r_m[0] ? ((r_m >> 1) + w_half) : (r_m >> 1);

    // Borrow of the single subtraction doubles as the dout0 >= q compare.
    assign w_diff  = {1'b0, dout0} - {1'b0, r_q};
    assign w_ge    = ~w_diff[DATA_W];
    assign w_wdata = w_ge ? w_diff[DATA_W-1:0] : dout0;
    assign w_over  = ({1'b0, dout0} >= {r_q, 1'b0});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_m         <= '0;
            r_ring_size <= '0;
            r_q         <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else if (arm) begin
            r_state     <= c_S_WAIT_DONE;
            r_m         <= '0;
            r_ring_size <= ring_size;
            r_q         <= q;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_S_WAIT_DONE: begin
                    if (done) begin
                        r_state <= c_S_CAPTURE;
                    end
                end
                c_S_CAPTURE: begin
                    if (dout_valid) begin
                        if (w_over) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= c_S_READY;
                        end else begin
                            r_m <= r_m + 1'b1;
                        end
                    end
                end
                c_S_READY: begin
                    if (dout_valid) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
    assign ready   = (r_state == c_S_READY);
    assign busy    = (r_state == c_S_WAIT_DONE) || (r_state == c_S_CAPTURE);
    assign ovf     = r_ovf;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ntt_result_collector.sv
// ============================================================================
// Module   : tb_ntt_result_collector
// Brief    : Directed, table-driven self-checking bench for ntt_result_collector.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_result_collector;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [11:0] ring_size;
    logic [31:0] q;
    logic        done;
    logic        dout_valid;
    logic [31:0] dout0;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ready;
    logic        busy;
    logic        ovf;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] words [0:1023];

    typedef struct {
        string            name;
        logic [31:0]      qv;
        logic [0:3][31:0] w;
        logic [0:3][31:0] e;
        logic             exp_err;
    } vec_t;

    vec_t vecs [4];

    ntt_result_collector #(
        .ADDR_W (c_ADDR_W),
        .DATA_W (c_DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .ring_size  (ring_size),
        .q          (q),
        .done       (done),
        .dout_valid (dout_valid),
        .dout0      (dout0),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ready      (ready),
        .busy       (busy),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = a[9:0];
        tick();
        d     = rd_data;
        rd_en = 1'b0;
    endtask

    // Arms, presents done together with a junk word, then streams words[0..ring-1].
    task automatic collect(input int ring, input logic [31:0] qv, input int gap, output int cyc);
        logic early;
        early     = 1'b0;
        arm       = 1'b1;
        ring_size = ring[11:0];
        q         = qv;
        tick();
        arm        = 1'b0;
        dout_valid = 1'b0;
        cyc        = 1;
        chk("busy_after_arm", {31'd0, busy}, 32'd1);
        chk("ready_after_arm", {31'd0, ready}, 32'd0);
        done       = 1'b1;
        dout_valid = 1'b1;
        dout0      = 32'hFFFF_FFF0;
        tick();
        cyc++;
        done = 1'b0;
        for (int m = 0; m < ring; m++) begin
            dout_valid = 1'b1;
            dout0      = words[m];
            if (m == ring - 1) early = ready;
            tick();
            cyc++;
            if (gap != 0 && ((m + 1) % gap) == 0 && m != ring - 1) begin
                dout_valid = 1'b0;
                tick();
                cyc++;
            end
        end
        dout_valid = 1'b0;
        while (!ready && cyc < ring + 300) begin
            tick();
            cyc++;
        end
        chk("ready_early", {31'd0, early}, 32'd0);
        chk("ready_seen", {31'd0, ready}, 32'd1);
    endtask

    task automatic check_pat256(input string name);
        logic [31:0] d;
        logic [31:0] e;
        for (int k = 0; k < 256; k++) begin
            rd(k, d);
            e = (k < 128) ? 32'(2 * k) : 32'(2 * (k - 128) + 1);
            chk(name, d, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [31:0] d;

        vecs[0] = '{name: "bnd_ok",  qv: 32'd3329,
                    w: {32'd3328, 32'd3329, 32'd6657, 32'd0},
                    e: {32'd3328, 32'd3328, 32'd0, 32'd0}, exp_err: 1'b0};
        vecs[1] = '{name: "bnd_err", qv: 32'd3329,
                    w: {32'd6658, 32'd3330, 32'd0, 32'd1},
                    e: {32'd3329, 32'd0, 32'd1, 32'd1}, exp_err: 1'b1};
        vecs[2] = '{name: "q17_err", qv: 32'd17,
                    w: {32'd20, 32'd5, 32'd34, 32'd16},
                    e: {32'd3, 32'd17, 32'd5, 32'd16}, exp_err: 1'b1};
        vecs[3] = '{name: "q17_ok",  qv: 32'd17,
                    w: {32'd16, 32'd17, 32'd33, 32'd0},
                    e: {32'd16, 32'd16, 32'd0, 32'd0}, exp_err: 1'b0};

        reset      = 1'b1;
        arm        = 1'b0;
        ring_size  = 12'd0;
        q          = 32'd0;
        done       = 1'b0;
        dout_valid = 1'b0;
        dout0      = 32'd0;
        rd_en      = 1'b0;
        rd_addr    = 10'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Back-to-back full collection.
        for (int m = 0; m < 256; m++) words[m] = 32'(m + 3329);
        collect(256, 32'd3329, 0, cyc);
        chk("b2b_latency", 32'(cyc), 32'd258);
        chk("b2b_busy", {31'd0, busy}, 32'd0);
        chk("b2b_ovf", {31'd0, ovf}, 32'd0);
        chk("b2b_err", {31'd0, err}, 32'd0);
        check_pat256("b2b_buf");

        // One idle cycle after every 16 words.
        collect(256, 32'd3329, 16, cyc);
        chk("gap_latency", 32'(cyc), 32'd273);
        chk("gap_ovf", {31'd0, ovf}, 32'd0);
        chk("gap_err", {31'd0, err}, 32'd0);
        check_pat256("gap_buf");

        // Boundary and small-ring vectors.
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 4; m++) words[m] = vecs[i].w[m];
            collect(4, vecs[i].qv, 0, cyc);
            chk({vecs[i].name, "_latency"}, 32'(cyc), 32'd6);
            chk({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_ovf"}, {31'd0, ovf}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                rd(k, d);
                chk({vecs[i].name, "_buf"}, d, vecs[i].e[k]);
            end
        end

        // Read port: data one cycle after rd_en, held while rd_en is low.
        rd_en   = 1'b1;
        rd_addr = 10'd1;
        #2;
        chk("rd_not_early", rd_data, 32'd0);
        tick();
        chk("rd_one_cycle", rd_data, 32'd16);
        rd_en   = 1'b0;
        rd_addr = 10'd2;
        tick();
        chk("rd_hold", rd_data, 32'd16);

        // Restart after 100 of 256 words; done held high throughout the partial run.
        arm       = 1'b1;
        ring_size = 12'd256;
        q         = 32'd3329;
        tick();
        arm  = 1'b0;
        done = 1'b1;
        tick();
        for (int m = 0; m < 100; m++) begin
            dout_valid = 1'b1;
            dout0      = 32'd3000;
            tick();
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_ready", {31'd0, ready}, 32'd0);
        done       = 1'b0;
        dout0      = 32'd9999;
        for (int m = 0; m < 256; m++) words[m] = 32'(m + 3329);
        collect(256, 32'd3329, 0, cyc);
        chk("rearm_latency", 32'(cyc), 32'd258);
        chk("rearm_err", {31'd0, err}, 32'd0);
        check_pat256("rearm_buf");

        // Extra words after ready must only flag overflow.
        for (int i = 0; i < 3; i++) begin
            dout_valid = 1'b1;
            dout0      = 32'd7;
            tick();
        end
        dout_valid = 1'b0;
        tick();
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_ready", {31'd0, ready}, 32'd1);
        chk("ovf_err", {31'd0, err}, 32'd0);
        check_pat256("ovf_buf");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
